// File: rtl/axi_mst_initiator.sv
// AXI3-style master traffic initiator: turns burst commands into AW/W/AR traffic and counts B/R completions.
// Optional response checking (ID/len/resp FIFOs driving out_err) is enabled by defining MST_RESP_CHECK_EN.
module axi_mst_initiator #(
  parameter int AXI_ADDR_W   = 32,
  parameter int AXI_ID_W     = 4,
  parameter int AXI_DATA_W   = 32,
  parameter int MST_OSTD_NUM = 4
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic                              in_cmd_valid,
  output logic                              out_cmd_ready,
  input  logic                              in_cmd_write,
  input  logic [AXI_ADDR_W-1:0]             in_cmd_addr,
  input  logic [3:0]                        in_cmd_len,
  input  logic [AXI_ID_W-1:0]               in_cmd_id,
  output logic                              out_awvalid,
  input  logic                              in_awready,
  output logic [AXI_ADDR_W-1:0]             out_awaddr,
  output logic [3:0]                        out_awlen,
  output logic [AXI_ID_W-1:0]               out_awid,
  output logic                              out_wvalid,
  input  logic                              in_wready,
  output logic                              out_wlast,
  output logic [AXI_DATA_W-1:0]             out_wdata,
  output logic [AXI_DATA_W/8-1:0]           out_wstrb,
  output logic [AXI_ID_W-1:0]               out_wid,
  input  logic                              in_bvalid,
  output logic                              out_bready,
  input  logic [AXI_ID_W-1:0]               in_bid,
  input  logic [1:0]                        in_bresp,
  output logic                              out_arvalid,
  input  logic                              in_arready,
  output logic [AXI_ADDR_W-1:0]             out_araddr,
  output logic [3:0]                        out_arlen,
  output logic [AXI_ID_W-1:0]               out_arid,
  input  logic                              in_rvalid,
  output logic                              out_rready,
  input  logic                              in_rlast,
  input  logic [AXI_ID_W-1:0]               in_rid,
  input  logic [1:0]                        in_rresp,
  input  logic [AXI_DATA_W-1:0]             in_rdata,
  output logic [$clog2(MST_OSTD_NUM):0]     out_wr_ostd,
  output logic [$clog2(MST_OSTD_NUM):0]     out_rd_ostd,
  output logic [15:0]                       out_wr_done,
  output logic [15:0]                       out_rd_done,
  output logic                              out_err
);

  localparam int OSTD_W = $clog2(MST_OSTD_NUM) + 1;
  localparam logic [OSTD_W-1:0] OSTD_MAX = OSTD_W'(MST_OSTD_NUM);
  localparam int STRB_W = AXI_DATA_W / 8;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_DATA = 2'd2} wstate_t;

  wstate_t                 r_wstate;
  wstate_t                 w_wstate_nxt;
  logic [AXI_ADDR_W-1:0]   r_aw_addr;
  logic [3:0]              r_aw_len;
  logic [AXI_ID_W-1:0]     r_aw_id;
  logic [3:0]              r_beat;
  logic                    r_arvalid;
  logic [AXI_ADDR_W-1:0]   r_ar_addr;
  logic [3:0]              r_ar_len;
  logic [AXI_ID_W-1:0]     r_ar_id;
  logic [OSTD_W-1:0]       r_wr_ostd;
  logic [OSTD_W-1:0]       r_rd_ostd;
  logic [15:0]             r_wr_done;
  logic [15:0]             r_rd_done;
  logic                    r_live;

  logic w_awvalid, w_wvalid, w_wlast;
  logic w_wr_room, w_rd_room, w_cmd_wr_acc, w_cmd_rd_acc;
  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_r_last_hs;
  logic [AXI_ADDR_W-1:0] w_wdata_sum;

  assign w_wr_room    = (r_wr_ostd < OSTD_MAX);
  assign w_rd_room    = (r_rd_ostd < OSTD_MAX);
  // r_live keeps every ready low until the first edge after reset release
  assign out_cmd_ready = r_live && (in_cmd_write ? ((r_wstate == W_IDLE) && w_wr_room)
                                                 : (!r_arvalid && w_rd_room));
  assign w_cmd_wr_acc = in_cmd_valid && in_cmd_write && out_cmd_ready;
  assign w_cmd_rd_acc = in_cmd_valid && !in_cmd_write && out_cmd_ready;

  assign w_aw_hs     = w_awvalid && in_awready;
  assign w_w_hs      = w_wvalid && in_wready;
  assign w_b_hs      = in_bvalid && r_live;
  assign w_ar_hs     = r_arvalid && in_arready;
  assign w_r_hs      = in_rvalid && r_live;
  assign w_r_last_hs = w_r_hs && in_rlast;

  // Write FSM: state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_wstate <= W_IDLE;
    else          r_wstate <= w_wstate_nxt;
  end

  // Write FSM: next state
  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_cmd_wr_acc) w_wstate_nxt = W_ADDR;
      W_ADDR:  if (in_awready) w_wstate_nxt = W_DATA;
      W_DATA:  if (in_wready && (r_beat == r_aw_len)) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write FSM: outputs
  always_comb begin
    w_awvalid = 1'b0;
    w_wvalid  = 1'b0;
    w_wlast   = 1'b0;
    out_wstrb = '0;
    case (r_wstate)
      W_ADDR: w_awvalid = 1'b1;
      W_DATA: begin
        w_wvalid  = 1'b1;
        w_wlast   = (r_beat == r_aw_len);
        out_wstrb = {STRB_W{1'b1}};
      end
      default: ;
    endcase
  end

  assign w_wdata_sum = r_aw_addr + AXI_ADDR_W'(r_beat);
  assign out_awvalid = w_awvalid;
  assign out_awaddr  = r_aw_addr;
  assign out_awlen   = r_aw_len;
  assign out_awid    = r_aw_id;
  assign out_wvalid  = w_wvalid;
  assign out_wlast   = w_wlast;
  assign out_wdata   = AXI_DATA_W'(w_wdata_sum);
  assign out_wid     = r_aw_id;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_aw_addr <= '0;
      r_aw_len  <= '0;
      r_aw_id   <= '0;
      r_beat    <= '0;
    end else begin
      if (w_cmd_wr_acc) begin
        r_aw_addr <= in_cmd_addr;
        r_aw_len  <= in_cmd_len;
        r_aw_id   <= in_cmd_id;
        r_beat    <= '0;
      end else if (w_w_hs) begin
        r_beat <= w_wlast ? 4'd0 : r_beat + 4'd1;
      end
    end
  end

  // Read address channel: single-entry holding register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_arvalid <= 1'b0;
      r_ar_addr <= '0;
      r_ar_len  <= '0;
      r_ar_id   <= '0;
    end else if (w_cmd_rd_acc) begin
      r_arvalid <= 1'b1;
      r_ar_addr <= in_cmd_addr;
      r_ar_len  <= in_cmd_len;
      r_ar_id   <= in_cmd_id;
    end else if (w_ar_hs) begin
      r_arvalid <= 1'b0;
    end
  end

  assign out_arvalid = r_arvalid;
  assign out_araddr  = r_ar_addr;
  assign out_arlen   = r_ar_len;
  assign out_arid    = r_ar_id;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ostd <= '0;
      r_rd_ostd <= '0;
      r_wr_done <= '0;
      r_rd_done <= '0;
      r_live    <= 1'b0;
    end else begin
      r_live <= 1'b1;
      case ({w_aw_hs, w_b_hs})
        2'b10:   r_wr_ostd <= r_wr_ostd + 1'b1;
        2'b01:   r_wr_ostd <= r_wr_ostd - 1'b1;
        default: ;
      endcase
      case ({w_ar_hs, w_r_last_hs})
        2'b10:   r_rd_ostd <= r_rd_ostd + 1'b1;
        2'b01:   r_rd_ostd <= r_rd_ostd - 1'b1;
        default: ;
      endcase
      if (w_b_hs)      r_wr_done <= r_wr_done + 16'd1;
      if (w_r_last_hs) r_rd_done <= r_rd_done + 16'd1;
    end
  end

  assign out_wr_ostd = r_wr_ostd;
  assign out_rd_ostd = r_rd_ostd;
  assign out_wr_done = r_wr_done;
  assign out_rd_done = r_rd_done;
  assign out_bready  = r_live;
  assign out_rready  = r_live;

`ifdef MST_RESP_CHECK_EN
  localparam int PTR_W = $clog2(MST_OSTD_NUM);

  logic [AXI_ID_W+3:0] r_wq [MST_OSTD_NUM];
  logic [AXI_ID_W+3:0] r_rq [MST_OSTD_NUM];
  logic [PTR_W-1:0]    r_wq_wp, r_wq_rp, r_rq_wp, r_rq_rp;
  logic [OSTD_W-1:0]   r_wq_cnt, r_rq_cnt;
  logic [3:0]          r_rbeat;
  logic                r_err;
  logic [AXI_ID_W+3:0] w_wq_head, w_rq_head;
  logic w_wq_push, w_wq_pop, w_rq_push, w_rq_pop, w_b_bad, w_r_bad;
  logic w_unused_ok;

  assign w_wq_head = r_wq[r_wq_rp];
  assign w_rq_head = r_rq[r_rq_rp];
  assign w_wq_push = w_aw_hs && (r_wq_cnt < OSTD_MAX);
  assign w_rq_push = w_ar_hs && (r_rq_cnt < OSTD_MAX);
  assign w_wq_pop  = w_b_hs && (r_wq_cnt != '0);
  assign w_rq_pop  = w_r_last_hs && (r_rq_cnt != '0);
  assign w_b_bad   = w_b_hs && ((r_wq_cnt == '0) || (in_bresp != 2'b00) ||
                                (in_bid != w_wq_head[AXI_ID_W+3:4]));
  // Beat count against the queued len catches both early and late RLAST
  assign w_r_bad   = w_r_hs && ((r_rq_cnt == '0) || (in_rresp != 2'b00) ||
                                (in_rid != w_rq_head[AXI_ID_W+3:4]) ||
                                (in_rlast != (r_rbeat == w_rq_head[3:0])));
  assign w_unused_ok = ^in_rdata;

  always_ff @(posedge aclk) begin
    if (w_wq_push) r_wq[r_wq_wp] <= {r_aw_id, r_aw_len};
    if (w_rq_push) r_rq[r_rq_wp] <= {r_ar_id, r_ar_len};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wq_wp  <= '0;
      r_wq_rp  <= '0;
      r_wq_cnt <= '0;
      r_rq_wp  <= '0;
      r_rq_rp  <= '0;
      r_rq_cnt <= '0;
      r_rbeat  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_wq_push) r_wq_wp <= r_wq_wp + 1'b1;
      if (w_wq_pop)  r_wq_rp <= r_wq_rp + 1'b1;
      if (w_rq_push) r_rq_wp <= r_rq_wp + 1'b1;
      if (w_rq_pop)  r_rq_rp <= r_rq_rp + 1'b1;
      case ({w_wq_push, w_wq_pop})
        2'b10:   r_wq_cnt <= r_wq_cnt + 1'b1;
        2'b01:   r_wq_cnt <= r_wq_cnt - 1'b1;
        default: ;
      endcase
      case ({w_rq_push, w_rq_pop})
        2'b10:   r_rq_cnt <= r_rq_cnt + 1'b1;
        2'b01:   r_rq_cnt <= r_rq_cnt - 1'b1;
        default: ;
      endcase
      if (w_r_hs) r_rbeat <= in_rlast ? 4'd0 : r_rbeat + 4'd1;
      if (w_b_bad || w_r_bad) r_err <= 1'b1;
    end
  end

  assign out_err = r_err;
`else
  logic w_unused_ok;
  assign w_unused_ok = ^{in_bid, in_bresp, in_rid, in_rresp, in_rdata};
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_mst_initiator.sv
// Directed bench for axi_mst_initiator: scoreboard queues for AW/W/AR payloads plus immediate-assert checks.
module tb_axi_mst_initiator;

`ifdef MST_RESP_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic        aclk, aresetn;
  logic        in_cmd_valid, out_cmd_ready, in_cmd_write;
  logic [31:0] in_cmd_addr;
  logic [3:0]  in_cmd_len;
  logic [3:0]  in_cmd_id;
  logic        out_awvalid, in_awready;
  logic [31:0] out_awaddr;
  logic [3:0]  out_awlen, out_awid;
  logic        out_wvalid, in_wready, out_wlast;
  logic [31:0] out_wdata;
  logic [3:0]  out_wstrb, out_wid;
  logic        in_bvalid, out_bready;
  logic [3:0]  in_bid;
  logic [1:0]  in_bresp;
  logic        out_arvalid, in_arready;
  logic [31:0] out_araddr;
  logic [3:0]  out_arlen, out_arid;
  logic        in_rvalid, out_rready, in_rlast;
  logic [3:0]  in_rid;
  logic [1:0]  in_rresp;
  logic [31:0] in_rdata;
  logic [2:0]  out_wr_ostd, out_rd_ostd;
  logic [15:0] out_wr_done, out_rd_done;
  logic        out_err;

  int checks = 0;
  int failures = 0;
  logic [63:0] aw_q[$];
  logic [63:0] w_q[$];
  logic [63:0] ar_q[$];

  axi_mst_initiator dut (
    .aclk(aclk), .aresetn(aresetn),
    .in_cmd_valid(in_cmd_valid), .out_cmd_ready(out_cmd_ready), .in_cmd_write(in_cmd_write),
    .in_cmd_addr(in_cmd_addr), .in_cmd_len(in_cmd_len), .in_cmd_id(in_cmd_id),
    .out_awvalid(out_awvalid), .in_awready(in_awready), .out_awaddr(out_awaddr),
    .out_awlen(out_awlen), .out_awid(out_awid),
    .out_wvalid(out_wvalid), .in_wready(in_wready), .out_wlast(out_wlast),
    .out_wdata(out_wdata), .out_wstrb(out_wstrb), .out_wid(out_wid),
    .in_bvalid(in_bvalid), .out_bready(out_bready), .in_bid(in_bid), .in_bresp(in_bresp),
    .out_arvalid(out_arvalid), .in_arready(in_arready), .out_araddr(out_araddr),
    .out_arlen(out_arlen), .out_arid(out_arid),
    .in_rvalid(in_rvalid), .out_rready(out_rready), .in_rlast(in_rlast),
    .in_rid(in_rid), .in_rresp(in_rresp), .in_rdata(in_rdata),
    .out_wr_ostd(out_wr_ostd), .out_rd_ostd(out_rd_ostd),
    .out_wr_done(out_wr_done), .out_rd_done(out_rd_done), .out_err(out_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_write(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id);
    aw_q.push_back({24'd0, addr, len, id});
    for (int b = 0; b <= int'(len); b++)
      w_q.push_back({23'd0, addr + 32'(b), 4'hF, (b == int'(len)), id});
  endtask

  task automatic drive_cmd(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                           input logic [3:0] id);
    in_cmd_valid = 1'b1;
    in_cmd_write = wr;
    in_cmd_addr  = addr;
    in_cmd_len   = len;
    in_cmd_id    = id;
    if (wr) push_write(addr, len, id);
    else    ar_q.push_back({24'd0, addr, len, id});
  endtask

  task automatic wait_w_drain(input string tag, input int budget);
    int n = 0;
    while (w_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(w_q.size()), 64'd0);
  endtask

  task automatic send_b(input logic [3:0] id, input logic [1:0] resp);
    in_bvalid = 1'b1;
    in_bid    = id;
    in_bresp  = resp;
    tick();
    in_bvalid = 1'b0;
  endtask

  // Scoreboard monitors sample away from the rising edge
  always @(negedge aclk) begin
    logic [63:0] e;
    if (aresetn) begin
      if (out_awvalid && in_awready) begin
        if (aw_q.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
        else begin
          e = aw_q.pop_front();
          check("aw_payload", {24'd0, out_awaddr, out_awlen, out_awid}, e);
        end
      end
      if (out_wvalid && in_wready) begin
        if (w_q.size() == 0) check("w_unexpected", 64'd1, 64'd0);
        else begin
          e = w_q.pop_front();
          check("w_beat", {23'd0, out_wdata, out_wstrb, out_wlast, out_wid}, e);
        end
      end
      if (out_arvalid && in_arready) begin
        if (ar_q.size() == 0) check("ar_unexpected", 64'd1, 64'd0);
        else begin
          e = ar_q.pop_front();
          check("ar_payload", {24'd0, out_araddr, out_arlen, out_arid}, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    aresetn = 1'b0;
    in_cmd_valid = 0; in_cmd_write = 0; in_cmd_addr = 0; in_cmd_len = 0; in_cmd_id = 0;
    in_awready = 0; in_wready = 0; in_bvalid = 0; in_bid = 0; in_bresp = 0;
    in_arready = 0; in_rvalid = 0; in_rlast = 0; in_rid = 0; in_rresp = 0; in_rdata = 0;
    #2;
    check("rst_valids", {out_awvalid, out_wvalid, out_arvalid, out_wlast}, 4'b0000);
    check("rst_readies", {out_cmd_ready, out_bready, out_rready}, 3'b000);
    check("rst_counters", {out_wr_ostd, out_rd_ostd, out_wr_done, out_rd_done}, 38'd0);
    check("rst_payload", {out_awaddr, out_wdata, out_araddr, out_wstrb}, 100'd0);
    check("rst_err", out_err, 1'b0);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    tick();
    check("live_readies", {out_bready, out_rready}, 2'b11);

    // Write len=3 id=2 at 0x100 with always-ready slave
    in_awready = 1; in_wready = 1; in_arready = 1;
    drive_cmd(1'b1, 32'h100, 4'd3, 4'd2);
    #1 check("wr_cmd_ready", out_cmd_ready, 1'b1);
    tick();
    in_cmd_valid = 0;
    check("aw_latency", out_awvalid, 1'b1);
    wait_w_drain("wr1_drain", 20);
    check("wr1_wvalid_off", out_wvalid, 1'b0);
    check("wr1_ostd", out_wr_ostd, 3'd1);
    send_b(4'd2, 2'b00);
    check("wr1_done", out_wr_done, 16'd1);
    check("wr1_ostd_clr", out_wr_ostd, 3'd0);

    // Read len=0 id=5 at 0x40 with arready stalled for 3 cycles
    in_arready = 0;
    drive_cmd(1'b0, 32'h40, 4'd0, 4'd5);
    tick();
    in_cmd_valid = 0;
    for (int i = 0; i < 3; i++) begin
      check("ar_hold_valid", out_arvalid, 1'b1);
      check("ar_hold_payload", {out_araddr, out_arlen, out_arid}, {32'h40, 4'd0, 4'd5});
      tick();
    end
    in_arready = 1;
    tick();
    check("ar_drop", out_arvalid, 1'b0);
    check("rd1_ostd", out_rd_ostd, 3'd1);
    in_rvalid = 1; in_rlast = 1; in_rid = 5; in_rresp = 0; in_rdata = 32'hCAFE;
    tick();
    in_rvalid = 0; in_rlast = 0;
    check("rd1_done", out_rd_done, 16'd1);
    check("rd1_ostd_clr", out_rd_ostd, 3'd0);

    // Fill read outstanding to 4, 5th blocked until one RLAST
    for (int i = 0; i < 4; i++) begin
      drive_cmd(1'b0, 32'h1000 + 32'(i * 16), 4'd0, 4'(8 + i));
      #1 check("fill_cmd_ready", out_cmd_ready, 1'b1);
      tick();
      in_cmd_valid = 0;
      tick();
    end
    check("full_ostd", out_rd_ostd, 3'd4);
    drive_cmd(1'b0, 32'h2000, 4'd0, 4'd12);
    #1 check("full_blocks", out_cmd_ready, 1'b0);
    tick(); tick();
    check("full_no_ar", out_arvalid, 1'b0);
    in_rvalid = 1; in_rlast = 1; in_rid = 8;
    tick();
    in_rvalid = 0;
    check("slot_freed", out_cmd_ready, 1'b1);
    tick();
    in_cmd_valid = 0;
    check("fifth_ar", out_arvalid, 1'b1);
    tick();
    check("refill_ostd", out_rd_ostd, 3'd4);
    in_rvalid = 1; in_rlast = 1;
    for (int i = 0; i < 4; i++) begin
      in_rid = 4'(9 + i);
      tick();
    end
    in_rvalid = 0; in_rlast = 0;
    check("drain_ostd", out_rd_ostd, 3'd0);
    check("drain_done", out_rd_done, 16'd6);

    // len=7 write with wready toggling 1,0,1,0
    in_wready = 0;
    drive_cmd(1'b1, 32'h200, 4'd7, 4'd3);
    tick();
    in_cmd_valid = 0;
    tick();
    begin
      int n = 0;
      while (w_q.size() != 0 && n < 60) begin
        in_wready = (n % 2 == 0);
        tick();
        n++;
      end
    end
    in_wready = 1;
    check("toggle_drain", 64'(w_q.size()), 64'd0);
    check("toggle_wvalid_off", out_wvalid, 1'b0);
    send_b(4'd3, 2'b00);
    check("toggle_done", out_wr_done, 16'd2);
    check("err_clean", out_err, 1'b0);

    // Read len=3 answered with RLAST on beat 2
    drive_cmd(1'b0, 32'h80, 4'd3, 4'd6);
    tick();
    in_cmd_valid = 0;
    tick();
    in_rvalid = 1; in_rid = 6; in_rresp = 0;
    for (int b = 0; b < 3; b++) begin
      in_rlast = (b == 2);
      tick();
    end
    in_rvalid = 0; in_rlast = 0;
    check("early_rlast_err", out_err, CHK);
    repeat (3) tick();
    check("err_sticky", out_err, CHK);
    check("early_rd_done", out_rd_done, 16'd7);

    // Reset asserted while W beat 2 is presented
    drive_cmd(1'b1, 32'h300, 4'd3, 4'd1);
    tick();
    in_cmd_valid = 0;
    repeat (3) tick();
    check("mid_beat2", {out_wvalid, out_wdata}, {1'b1, 32'h302});
    aresetn = 1'b0;
    #1;
    check("async_valids", {out_awvalid, out_wvalid, out_arvalid, out_wlast}, 4'b0000);
    check("async_readies", {out_cmd_ready, out_bready, out_rready}, 3'b000);
    check("async_counters", {out_wr_ostd, out_rd_ostd, out_wr_done, out_rd_done}, 38'd0);
    check("async_payload", {out_awaddr, out_wdata, out_wstrb}, 68'd0);
    check("async_err", out_err, 1'b0);
    w_q.delete();
    aw_q.delete();
    tick();
    aresetn = 1'b1;
    tick(); tick();
    drive_cmd(1'b1, 32'h400, 4'd1, 4'd4);
    #1 check("post_rst_ready", out_cmd_ready, 1'b1);
    tick();
    in_cmd_valid = 0;
    wait_w_drain("post_rst_drain", 20);
    send_b(4'd4, 2'b10);
    check("post_rst_done", out_wr_done, 16'd1);
    check("bresp_err", out_err, CHK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
